instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/seq_outdec.sv | 64 ++++++
 rtl/vDFFE.sv | 18 +
 rtl/instr_sequencer.sv | 82 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction sequencer: state
// enumeration, opcode/op class constants, one-hot register selects and
// writeback source selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_ALU    = 3'd5,
    S_WR_REG = 3'd6
  } state_t;

  // Instruction classes
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Sub-operations within each class
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // One-hot register file selects
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  // Writeback source selects
  localparam logic [1:0] VSEL_NONE = 2'b00;
  localparam logic [1:0] VSEL_IMM  = 2'b01;
  localparam logic [1:0] VSEL_C    = 2'b11;

  // CMP only updates status; it never loads C or writes back.
  function automatic logic is_cmp(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OPC_ALU) && (op == OP_CMP);
  endfunction

  // Single-operand operations route A to zero (asel) and skip GET_A.
  function automatic logic is_single_operand(input logic [2:0] opcode, input logic [1:0] op);
    return ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
           ((opcode == OPC_ALU) && (op == OP_MVN));
  endfunction

endpackage

// File: rtl/seq_outdec.sv
// Moore output decode for the instruction sequencer. Outputs depend on the
// current state; in ALU the held opcode/op refine which strobes fire.
module seq_outdec
  import cpu_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_op,
  output logic       o_w,
  output logic [2:0] o_nsel,
  output logic [1:0] o_vsel,
  output logic       o_write,
  output logic       o_loada,
  output logic       o_loadb,
  output logic       o_loadc,
  output logic       o_loads,
  output logic       o_asel,
  output logic       o_bsel
);

  // Per-state datapath strobes; everything idles low unless a state asserts it.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_w     = 1'b0;
    o_nsel  = NSEL_NONE;
    o_vsel  = VSEL_NONE;
    o_write = 1'b0;
    o_loada = 1'b0;
    o_loadb = 1'b0;
    o_loadc = 1'b0;
    o_loads = 1'b0;
    o_asel  = 1'b0;
    o_bsel  = 1'b0;
    case (i_state)
      S_WAIT: o_w = 1'b1;
      S_WR_IMM: begin
        o_nsel  = NSEL_RN;
        o_vsel  = VSEL_IMM;
        o_write = 1'b1;
      end
      S_GET_A: begin
        o_nsel  = NSEL_RN;
        o_loada = 1'b1;
      end
      S_GET_B: begin
        o_nsel  = NSEL_RM;
        o_loadb = 1'b1;
      end
      S_ALU: begin
        o_asel  = is_single_operand(i_opcode, i_op);
        o_loadc = !is_cmp(i_opcode, i_op);
        o_loads = is_cmp(i_opcode, i_op);
      end
      S_WR_REG: begin
        o_nsel  = NSEL_RD;
        o_vsel  = VSEL_C;
        o_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vDFFE.sv
// Load-enabled register used throughout the datapath and control.
module vDFFE #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  // Capture i_d on the rising edge when enabled.
  // NOTE: no reset here; callers that need one put a reset mux on i_d so the
  // same register cell serves both reset and non-reset state.
  always_ff @(posedge clk) begin
    if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Control FSM sequencing register reads, ALU operation and writeback for
// MOV and ALU-class instructions. State lives in a vDFFE with a reset mux.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel
);

  logic [2:0] w_state_q;
  state_t     w_state;
  state_t     w_next;
  state_t     w_next_rst;

  assign w_state = state_t'(w_state_q);

  // Next-state selection; opcode/op are held stable from DECODE onward.
  always_comb begin
    w_next = S_WAIT;
    case (w_state)
      S_WAIT:   w_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if ((opcode == OPC_MOV) && (op == OP_MOV_IMM))
          w_next = S_WR_IMM;
        else if (is_single_operand(opcode, op))
          w_next = S_GET_B;
        else if (opcode == OPC_ALU)
          w_next = S_GET_A;
        else
          w_next = S_WAIT;
      end
      S_WR_IMM: w_next = S_WAIT;
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_ALU;
      S_ALU:    w_next = is_cmp(opcode, op) ? S_WAIT : S_WR_REG;
      S_WR_REG: w_next = S_WAIT;
      default:  w_next = S_WAIT;
    endcase
  end

  // Reset wins over any transition, aborting a pending write.
  always_comb begin
    w_next_rst = reset ? S_WAIT : w_next;
  end

  vDFFE #(.N(3)) u_state_reg (
    .clk  (clk),
    .i_en (1'b1),
    .i_d  (w_next_rst),
    .o_q  (w_state_q)
  );

  seq_outdec u_outdec (
    .i_state  (w_state),
    .i_opcode (opcode),
    .i_op     (op),
    .o_w      (w),
    .o_nsel   (nsel),
    .o_vsel   (vsel),
    .o_write  (write),
    .o_loada  (loada),
    .o_loadb  (loadb),
    .o_loadc  (loadc),
    .o_loads  (loads),
    .o_asel   (asel),
    .o_bsel   (bsel)
  );

endmodule
